// File: rtl/mul_writeback.sv
// mul_writeback -- downstream stage of the 3-cycle signed multiplier.
//
// Purpose:
//   Records per-op metadata (funct, destination tag, sign-correction term) at issue.
//   Pairs each multiplier product with its metadata in issue order.
//   Selects the RV32M result (MUL/MULH/MULHSU/MULHU) and buffers it in a result FIFO.
//   Presents each result on a valid/ready writeback port.
//   Throttles issue with a credit count so that results can never overflow the buffer.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   issue_valid/funct/tag/     op issued to the multiplier this cycle
//     rs1/rs2
//   issue_ready                issue allowed this cycle
//   mul_lo/mul_hi/mul_valid    signed product from the multiplier, MUL_LAT after issue
//   flush                      kill all in-flight and buffered ops
//   wb_valid/wb_ready          writeback handshake
//   wb_tag/wb_data             writeback payload
//   proto_err                  sticky: product arrived with no matching metadata
//
// Configuration:
//   MUL_WB_BYPASS_EN  When defined, a product arriving while the result FIFO is empty is
//                     driven combinationally onto wb_* in the same cycle.
//                     When undefined, wb_* is the registered FIFO head only.

module mul_writeback #(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [1:0]       issue_funct,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [31:0]      issue_rs1,
  input  logic [31:0]      issue_rs2,
  output logic             issue_ready,
  input  logic [31:0]      mul_lo,
  input  logic [31:0]      mul_hi,
  input  logic             mul_valid,
  input  logic             flush,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic             proto_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MUL_LAT == 0) begin : g_param_check
    $error("mul_writeback: DEPTH must be a power of 2 >= 2 and MUL_LAT >= 1");
  end

  // Metadata FIFO
  logic [1:0]       r_mf_funct [DEPTH];
  logic [TAG_W-1:0] r_mf_tag   [DEPTH];
  logic [31:0]      r_mf_corr  [DEPTH];
  logic [PW-1:0]    r_mf_wp, r_mf_rp;
  logic [CW-1:0]    r_mf_cnt;

  // Result FIFO
  logic [TAG_W-1:0] r_rf_tag  [DEPTH];
  logic [31:0]      r_rf_data [DEPTH];
  logic [PW-1:0]    r_rf_wp, r_rf_rp;
  logic [CW-1:0]    r_rf_cnt;

  logic [CW-1:0]    r_drop_cnt;
  logic             r_proto_err;

  logic [CW+1:0]    w_credit_used;
  logic             w_issue;
  logic [31:0]      w_corr;
  logic             w_mv_drop;
  logic             w_mv_orphan;
  logic             w_mv_take;
  logic [31:0]      w_res_data;
  logic [TAG_W-1:0] w_res_tag;
  logic             w_res_push;
  logic             w_res_pop;
  logic [CW:0]      w_pend;
  logic [CW:0]      w_flush_drop;

  always_comb begin
    w_credit_used = (CW+2)'(r_mf_cnt) + (CW+2)'(r_rf_cnt) + (CW+2)'(r_drop_cnt);
    issue_ready   = w_credit_used < (CW+2)'(DEPTH);
    w_issue       = issue_valid & issue_ready & ~flush;
  end

  // Correction turns the signed high word into the mixed/unsigned high word.
  always_comb begin
    w_corr = '0;
    case (issue_funct)
      2'b10:   w_corr = issue_rs2[31] ? issue_rs1 : '0;
      2'b11:   w_corr = (issue_rs1[31] ? issue_rs2 : '0) + (issue_rs2[31] ? issue_rs1 : '0);
      default: w_corr = '0;
    endcase
  end

  always_comb begin
    w_mv_drop   = mul_valid & (r_drop_cnt != '0);
    w_mv_orphan = mul_valid & (r_drop_cnt == '0) & (r_mf_cnt == '0);
    w_mv_take   = mul_valid & (r_drop_cnt == '0) & (r_mf_cnt != '0) & ~flush;
    w_res_tag   = r_mf_tag[r_mf_rp];
    w_res_data  = '0;
    case (r_mf_funct[r_mf_rp])
      2'b00:   w_res_data = mul_lo;
      2'b01:   w_res_data = mul_hi;
      default: w_res_data = mul_hi + r_mf_corr[r_mf_rp];
    endcase
  end

`ifdef MUL_WB_BYPASS_EN
  logic w_bypass;
  always_comb begin
    w_bypass   = w_mv_take & (r_rf_cnt == '0);
    wb_valid   = (r_rf_cnt != '0) | w_bypass;
    wb_tag     = w_bypass ? w_res_tag  : r_rf_tag[r_rf_rp];
    wb_data    = w_bypass ? w_res_data : r_rf_data[r_rf_rp];
    // A bypassed result consumed this cycle never enters the FIFO.
    w_res_push = w_mv_take & ~(w_bypass & wb_ready);
    w_res_pop  = (r_rf_cnt != '0) & wb_ready & ~flush;
  end
`else
  always_comb begin
    wb_valid   = r_rf_cnt != '0;
    wb_tag     = r_rf_tag[r_rf_rp];
    wb_data    = r_rf_data[r_rf_rp];
    w_res_push = w_mv_take;
    w_res_pop  = wb_valid & wb_ready & ~flush;
  end
`endif

  // Every op still owed by the multiplier (queued metadata plus pending drops) must be
  // discarded after a flush, less the one whose product arrives in the flush cycle itself.
  always_comb begin
    w_pend       = (CW+1)'(r_drop_cnt) + (CW+1)'(r_mf_cnt);
    w_flush_drop = (mul_valid && w_pend != '0) ? w_pend - (CW+1)'(1) : w_pend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mf_funct[i] <= '0;
        r_mf_tag[i]   <= '0;
        r_mf_corr[i]  <= '0;
        r_rf_tag[i]   <= '0;
        r_rf_data[i]  <= '0;
      end
      r_mf_wp     <= '0;
      r_mf_rp     <= '0;
      r_mf_cnt    <= '0;
      r_rf_wp     <= '0;
      r_rf_rp     <= '0;
      r_rf_cnt    <= '0;
      r_drop_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_mv_orphan) r_proto_err <= 1'b1;
      if (flush) begin
        r_mf_wp    <= '0;
        r_mf_rp    <= '0;
        r_mf_cnt   <= '0;
        r_rf_wp    <= '0;
        r_rf_rp    <= '0;
        r_rf_cnt   <= '0;
        r_drop_cnt <= CW'(w_flush_drop);
      end else begin
        if (w_issue) begin
          r_mf_funct[r_mf_wp] <= issue_funct;
          r_mf_tag[r_mf_wp]   <= issue_tag;
          r_mf_corr[r_mf_wp]  <= w_corr;
          r_mf_wp             <= r_mf_wp + PW'(1);
        end
        if (w_mv_take) r_mf_rp <= r_mf_rp + PW'(1);
        r_mf_cnt <= r_mf_cnt + CW'(w_issue) - CW'(w_mv_take);

        if (w_res_push) begin
          r_rf_tag[r_rf_wp]  <= w_res_tag;
          r_rf_data[r_rf_wp] <= w_res_data;
          r_rf_wp            <= r_rf_wp + PW'(1);
        end
        if (w_res_pop) r_rf_rp <= r_rf_rp + PW'(1);
        r_rf_cnt <= r_rf_cnt + CW'(w_res_push) - CW'(w_res_pop);

        r_drop_cnt <= r_drop_cnt - CW'(w_mv_drop);
      end
    end
  end

  assign proto_err = r_proto_err;

endmodule
